// File: rtl/xor_bit_serializer_pkg.sv
// Package: xor_bit_serializer_pkg
//   Shared definitions for the XOR bit serializer and its holding buffer:
//   FSM state encoding, the supported width ceiling and the index-width helper.
package xor_bit_serializer_pkg;

   typedef enum logic {
      XSER_IDLE  = 1'b0,
      XSER_SHIFT = 1'b1
   } xser_state_t;

   localparam int unsigned XSER_MAX_WIDTH = 32;

   // Bit index counter width: $clog2(width), but never narrower than one bit.
   function automatic int unsigned xser_idx_width(input int unsigned width);
      return (width <= 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/xor_bit_serializer_skid_buf.sv
// Module: xser_skid_buf
//   One-entry valid/ready holding buffer. Lets the serializer take the next
//   word while the current one is still being shifted out.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wr_valid/wr_ready   write handshake (wr_ready = buffer empty)
//   wr_data             word to hold
//   rd_valid            buffer holds a word
//   rd_ready            consumer takes the held word this edge
//   rd_data             held word
module xser_skid_buf #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data
);

   logic             full_q;
   logic [WIDTH-1:0] data_q;
   logic             write_en;

   assign wr_ready = ~full_q;
   assign rd_valid = full_q;
   assign rd_data  = data_q;

   // A write that coincides with a read replaces the entry and keeps it full.
   assign write_en = wr_valid & (~full_q | rd_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else if (write_en) begin
         full_q <= 1'b1;
         data_q <= wr_data;
      end else if (rd_ready) begin
         full_q <= 1'b0;
      end
   end

endmodule

// File: rtl/xor_bit_serializer.sv
// Module: xor_bit_serializer
//   Feeds a DFF-based XOR accumulator: takes WIDTH-bit words over valid/ready
//   and emits one bit per clock with a same-cycle qualifier (bit_en), so the
//   accumulator can compute d = (bit_out & bit_en) ^ q without skew.
// Parameters:
//   WIDTH      word width, 1..32
//   LSB_FIRST  1: bit 0 first, 0: bit WIDTH-1 first
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   word handshake; in_data sampled only on transfer
//   stall               downstream hold, freezes shifting
//   bit_out             current serial bit (flop output)
//   bit_en              bit_out consumed this cycle (shifting & ~stall)
//   last                bit_out is the final bit of the word (flop output)
//   busy                a word is shifting or buffered
// Build option:
//   XSER_SKID_EN  adds a one-entry holding buffer for zero-bubble streaming;
//                 without it there is one idle cycle between words.
module xor_bit_serializer
   import xor_bit_serializer_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             stall,
   output logic             bit_out,
   output logic             bit_en,
   output logic             last,
   output logic             busy
);

   localparam int unsigned       IDX_W    = xser_idx_width(WIDTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   if (WIDTH < 1 || WIDTH > XSER_MAX_WIDTH) begin : g_width_check
      $error("xor_bit_serializer: WIDTH out of range");
   end

   xser_state_t      state_q;
   logic [WIDTH-1:0] shift_q;
   logic [IDX_W-1:0] index_q;
   logic             last_q;

   logic             shifting;
   logic             accept;
   logic             word_done;
   logic             buf_full;
   logic [WIDTH-1:0] buf_data;
   logic             load_en;
   logic [WIDTH-1:0] load_data;

   assign shifting  = (state_q == XSER_SHIFT);
   assign bit_en    = shifting & ~stall;
   assign accept    = in_valid & in_ready;
   assign word_done = bit_en & last_q;
   assign last      = last_q;
   assign busy      = shifting | buf_full;

   // The current bit always sits at the outgoing end of the shift register,
   // so bit_out is a flop output with no extra mux stage.
   assign bit_out = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];

`ifdef XSER_SKID_EN
   logic buf_wr;
   logic buf_pop;

   // A word arriving on the final bit with the buffer empty bypasses the
   // buffer and loads straight into the shifter; otherwise, while shifting,
   // it is parked in the buffer.
   assign buf_wr  = accept & shifting & ~(word_done & ~buf_full);
   assign buf_pop = word_done & buf_full;

   xser_skid_buf #(
      .WIDTH (WIDTH)
   ) u_skid_buf (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (buf_wr),
      .wr_ready (in_ready),
      .wr_data  (in_data),
      .rd_valid (buf_full),
      .rd_ready (buf_pop),
      .rd_data  (buf_data)
   );
`else
   assign in_ready = ~shifting;
   assign buf_full = 1'b0;
   assign buf_data = '0;
`endif

   // Select when and from where a fresh word enters the shifter.
   always_comb begin
      load_en   = 1'b0;
      load_data = in_data;
      if (!shifting) begin
         load_en = accept;
      end else if (word_done) begin
         if (buf_full) begin
            load_en   = 1'b1;
            load_data = buf_data;
         end else begin
            load_en = accept;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= XSER_IDLE;
         shift_q <= '0;
         index_q <= '0;
         last_q  <= 1'b0;
      end else if (load_en) begin
         state_q <= XSER_SHIFT;
         shift_q <= load_data;
         index_q <= '0;
         last_q  <= (WIDTH == 1);
      end else if (word_done) begin
         state_q <= XSER_IDLE;
         index_q <= '0;
         last_q  <= 1'b0;
      end else if (bit_en) begin
         shift_q <= LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
         index_q <= index_q + IDX_ONE;
         last_q  <= ((index_q + IDX_ONE) == IDX_LAST);
      end
   end

endmodule

// File: tb/tb_xor_bit_serializer.sv
module tb_xor_bit_serializer;

   localparam int NCFG = 3;

   function automatic int cfg_w(input int g);
      case (g)
         0:       return 8;
         1:       return 1;
         default: return 5;
      endcase
   endfunction

   function automatic bit cfg_lsb(input int g);
      return (g != 2);
   endfunction

`ifdef XSER_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   typedef struct {
      bit b;
      bit l;
      bit qb;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int errors   = 0;
   int done_cnt = 0;

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int W    = cfg_w(g);
      localparam bit LSBF = cfg_lsb(g);

      logic         reset    = 1'b1;
      logic         in_valid = 1'b0;
      logic         stall    = 1'b0;
      logic [W-1:0] in_data  = '0;
      logic         in_ready, bit_out, bit_en, last, busy;
      logic         q;

      exp_t eq[$];
      exp_t mon_e;
      bit   macc       = 1'b0;
      int   span_first = -1;
      int   span_last  = -1;
      int   cyc        = 0;

      xor_bit_serializer #(
         .WIDTH     (W),
         .LSB_FIRST (LSBF)
      ) dut (
         .clk      (clk),
         .reset    (reset),
         .in_valid (in_valid),
         .in_ready (in_ready),
         .in_data  (in_data),
         .stall    (stall),
         .bit_out  (bit_out),
         .bit_en   (bit_en),
         .last     (last),
         .busy     (busy)
      );

      // Downstream XOR accumulator
      always @(posedge clk) begin
         if (reset) q <= 1'b0;
         else       q <= (bit_out & bit_en) ^ q;
      end

      task automatic chkb(input string name, input logic act, input logic exp);
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %b expected %b", g, name, act, exp);
         end
      endtask

      task automatic chki(input string name, input int act, input int exp);
         checks++;
         if (act != exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0d expected %0d", g, name, act, exp);
         end
      endtask

      // Reference: word bits in emission order, with running parity before each.
      task automatic push_word(input logic [W-1:0] d);
         exp_t e;
         for (int i = 0; i < W; i++) begin
            e.b  = LSBF ? d[i] : d[W-1-i];
            e.l  = (i == W - 1);
            e.qb = macc;
            macc = macc ^ e.b;
            eq.push_back(e);
         end
      endtask

      // Called at posedge+1 with inputs set; records transfer, advances a cycle.
      task automatic step(output bit acc);
         acc = in_valid & in_ready & ~reset;
         if (reset) begin
            eq.delete();
            macc = 1'b0;
         end else if (acc) begin
            push_word(in_data);
         end
         if (bit_en && !reset) begin
            if (span_first < 0) span_first = cyc;
            span_last = cyc;
         end
         cyc++;
         @(posedge clk);
         #1;
      endtask

      task automatic send(input logic [W-1:0] d, input bit keep);
         bit a;
         int n = 0;
         in_valid = 1'b1;
         in_data  = d;
         do begin
            step(a);
            n++;
         end while (!a && n < 100);
         if (!keep) in_valid = 1'b0;
         in_data = W'($urandom);
         chkb("send_accept", a, 1'b1);
      endtask

      task automatic drain(input string name);
         bit a;
         int n = 0;
         stall    = 1'b0;
         in_valid = 1'b0;
         while ((eq.size() != 0 || busy) && n < 200) begin
            step(a);
            n++;
         end
         chkb({name, "_drain_in_time"}, n < 200, 1'b1);
         chkb({name, "_final_q"}, q, macc);
      endtask

      // Monitor: every qualified bit is popped and compared.
      always @(negedge clk) begin
         if (!reset) begin
            if (stall) chkb("stall_gates_bit_en", bit_en, 1'b0);
            if (bit_en) begin
               if (eq.size() == 0) begin
                  chkb("spurious_bit_en", bit_en, 1'b0);
               end else begin
                  mon_e = eq.pop_front();
                  chkb("bit_out", bit_out, mon_e.b);
                  chkb("last", last, mon_e.l);
                  chkb("acc_q", q, mon_e.qb);
               end
            end
         end
      end

      initial begin : stim
         bit   a;
         logic hold;
         #1;
         // Reset held two cycles
         reset = 1'b1;
         step(a);
         step(a);
         reset = 1'b0;
         chkb("rst_in_ready", in_ready, 1'b1);
         chkb("rst_bit_en", bit_en, 1'b0);
         chkb("rst_busy", busy, 1'b0);
         chkb("rst_last", last, 1'b0);
         chkb("rst_bit_out", bit_out, 1'b0);

         // Single word, first bit the cycle after transfer
         in_valid = 1'b1;
         in_data  = W'(32'hA5);
         step(a);
         chkb("a5_accept", a, 1'b1);
         in_valid = 1'b0;
         chkb("first_bit_latency", bit_en, 1'b1);
         drain("a5");

         // Stall for three cycles after the second bit is consumed
         send(W'(32'h07), 1'b0);
         step(a);
         step(a);
         stall = 1'b1;
         hold  = bit_out;
         repeat (3) begin
            step(a);
            chkb("stall_bit_en", bit_en, 1'b0);
            chkb("stall_bit_out_hold", bit_out, hold);
         end
         drain("s07");

         // Back-to-back words with in_valid held
         span_first = -1;
         span_last  = -1;
         send(W'(32'hFF), 1'b1);
         send(W'(32'h01), 1'b0);
         drain("b2b");
         chki("b2b_bit_span", span_last - span_first + 1, SKID ? 2 * W : 2 * W + 1);

         // Reset at the fourth bit of a word
         send(W'(32'hF0), 1'b0);
         repeat (3) step(a);
         reset = 1'b1;
         step(a);
         reset = 1'b0;
         chkb("midrst_bit_en", bit_en, 1'b0);
         chkb("midrst_busy", busy, 1'b0);
         chkb("midrst_last", last, 1'b0);
         chkb("midrst_bit_out", bit_out, 1'b0);
         chkb("midrst_q", q, 1'b0);
         repeat (4) step(a);
         chkb("midrst_still_idle", busy, 1'b0);
         chkb("midrst_q_after", q, 1'b0);

         // Stream of three words
         send(W'(32'h1), 1'b1);
         send(W'(32'h1), 1'b1);
         send(W'(32'h0), 1'b0);
         drain("stream");

         // Random traffic with stalls and occasional resets
         for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(9) < 6);
            in_data  = W'($urandom);
            stall    = ($urandom_range(3) == 0);
            reset    = ($urandom_range(99) == 0);
            step(a);
         end
         reset = 1'b0;
         drain("random");

         done_cnt++;
      end
   end

   initial begin : summary
      int n = 0;
      while (done_cnt < NCFG && n < 50000) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (done_cnt < NCFG) begin
         errors++;
         $display("FAIL timeout: configs done %0d expected %0d", done_cnt, NCFG);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
